vga_image_fetch: RTL and testbench

Downstream of the three colour ROMs (`rom_red`, `rom_green`, `rom_blue`, 160 000 × 8-bit, one-clock registered read). Generates 640×480@60 Hz VGA timing and produces the ROM read address for a 400×400 image centred on screen. Aligns the returned 8-bit colour samples with delayed sync and blanking, and drives the VGA DAC outputs.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_timing.sv | 71 +++++++
 rtl/vga_image_fetch.sv | 143 ++++++++++++++
 tb/tb_vga_image_fetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// 640x480@60 timing constants and default image geometry shared by the
// timing generator and the image fetch datapath.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_END = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_END = cnt_t'(V_VIS);
    localparam cnt_t HS_FIRST  = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_END    = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t VS_FIRST  = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_END    = cnt_t'(V_VIS + V_FP + V_SYNC);

    localparam int          IMG_W_DEF = 400;
    localparam int          IMG_H_DEF = 400;
    localparam int          X0_DEF    = 120;
    localparam int          Y0_DEF    = 40;
    localparam logic [7:0]  BG_DEF    = 8'h00;

    localparam int IMG_AW = 18;
    typedef logic [IMG_AW-1:0] img_addr_t;

    // Half-open interval test lo <= val < hi.
    function automatic logic in_span(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider plus h/v raster counters; decodes visible area, sync
// windows and the start-of-frame pulse for the current counter position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick,
    output cnt_t h,
    output cnt_t v,
    output logic de,
    output logic hs,
    output logic vs,
    output logic frame_start
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    cnt_t          h_q, h_d;
    cnt_t          v_q, v_d;
    logic          frame_start_q, frame_start_d;

    assign pix_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d     = div_cnt_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (pix_tick) begin
            div_cnt_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h           = h_q;
    assign v           = v_q;
    assign de          = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign hs          = in_span(h_q, HS_FIRST, HS_END);
    assign vs          = in_span(v_q, VS_FIRST, VS_END);
    assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_image_fetch.sv
// Raster-order ROM address generation for a centred image and two pixel-rate
// stages that line the returned colour up with sync and blanking.
module vga_image_fetch
    import vga_pkg::*;
#(
    parameter int         CLK_DIV = 2,
    parameter int         IMG_W   = IMG_W_DEF,
    parameter int         IMG_H   = IMG_H_DEF,
    parameter int         X0      = X0_DEF,
    parameter int         Y0      = Y0_DEF,
    parameter logic [7:0] BG      = BG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [23:0] red_data,
    input  logic [23:0] green_data,
    input  logic [23:0] blue_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam cnt_t X_LO = cnt_t'(X0);
    localparam cnt_t X_HI = cnt_t'(X0 + IMG_W);
    localparam cnt_t Y_LO = cnt_t'(Y0);
    localparam cnt_t Y_HI = cnt_t'(Y0 + IMG_H);

    logic pix_tick, de, hs, vs;
    cnt_t h, v;

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .h           (h),
        .v           (v),
        .de          (de),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start)
    );

    logic      in_img, at_origin;
    img_addr_t addr_base;
    img_addr_t img_addr_q, img_addr_d, rom_addr_q, rom_addr_d;
    logic      a_in_img_q, a_in_img_d, a_de_q, a_de_d, a_hs_q, a_hs_d, a_vs_q, a_vs_d;
    logic [7:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
    logic      vga_hsync_q, vga_hsync_d, vga_vsync_q, vga_vsync_d, vga_blank_n_q, vga_blank_n_d;
    logic      unused_rom_bits;

    assign in_img    = in_span(h, X_LO, X_HI) && in_span(v, Y_LO, Y_HI);
    assign at_origin = (h == '0) && (v == '0);
    // The (0,0) clear takes priority so a new frame never inherits a stale count.
    assign addr_base = at_origin ? '0 : img_addr_q;
    assign unused_rom_bits = ^{red_data[23:8], green_data[23:8], blue_data[23:8]};

    always_comb begin
        img_addr_d    = img_addr_q;
        rom_addr_d    = rom_addr_q;
        a_in_img_d    = a_in_img_q;
        a_de_d        = a_de_q;
        a_hs_d        = a_hs_q;
        a_vs_d        = a_vs_q;
        vga_r_d       = vga_r_q;
        vga_g_d       = vga_g_q;
        vga_b_d       = vga_b_q;
        vga_hsync_d   = vga_hsync_q;
        vga_vsync_d   = vga_vsync_q;
        vga_blank_n_d = vga_blank_n_q;
        if (pix_tick) begin
            img_addr_d = addr_base;
            if (in_img) begin
                rom_addr_d = addr_base;
                img_addr_d = addr_base + 1'b1;
            end
            a_in_img_d = in_img;
            a_de_d     = de;
            a_hs_d     = hs;
            a_vs_d     = vs;
            // ROM data for the stage-A pixel has been valid since one clk after the previous tick.
            if (a_in_img_q) begin
                vga_r_d = red_data[7:0];
                vga_g_d = green_data[7:0];
                vga_b_d = blue_data[7:0];
            end else if (a_de_q) begin
                vga_r_d = BG;
                vga_g_d = BG;
                vga_b_d = BG;
            end else begin
                vga_r_d = '0;
                vga_g_d = '0;
                vga_b_d = '0;
            end
            vga_hsync_d   = ~a_hs_q;
            vga_vsync_d   = ~a_vs_q;
            vga_blank_n_d = a_de_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_addr_q    <= '0;
            rom_addr_q    <= '0;
            a_in_img_q    <= 1'b0;
            a_de_q        <= 1'b0;
            a_hs_q        <= 1'b0;
            a_vs_q        <= 1'b0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hsync_q   <= 1'b1;
            vga_vsync_q   <= 1'b1;
            vga_blank_n_q <= 1'b0;
        end else begin
            img_addr_q    <= img_addr_d;
            rom_addr_q    <= rom_addr_d;
            a_in_img_q    <= a_in_img_d;
            a_de_q        <= a_de_d;
            a_hs_q        <= a_hs_d;
            a_vs_q        <= a_vs_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            vga_hsync_q   <= vga_hsync_d;
            vga_vsync_q   <= vga_vsync_d;
            vga_blank_n_q <= vga_blank_n_d;
        end
    end

    assign rom_addr    = {{(32-IMG_AW){1'b0}}, rom_addr_q};
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign vga_blank_n = vga_blank_n_q;

endmodule

// File: tb/tb_vga_image_fetch.sv
// Bench for vga_image_fetch: two instances (CLK_DIV 2 and 4) with a short image
// so several image rows fit in a short run; raster reference model per cycle.
module tb_vga_image_fetch;

    localparam int         TX0  = 120;
    localparam int         TW   = 400;
    localparam int         TY0  = 2;
    localparam int         TH   = 3;
    localparam logic [7:0] TBG  = 8'h5A;
    localparam int HTOT  = 800;
    localparam int HVIS  = 640;
    localparam int VVIS  = 480;
    localparam int HS_LO = 656;
    localparam int HS_HI = 752;
    localparam int VS_LO = 490;
    localparam int VS_HI = 492;
    localparam int GUARD = 100000;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } out_t;

    localparam out_t RESET_OUT = '{addr: 32'd0, r: 8'd0, g: 8'd0, b: 8'd0,
                                   hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0};

    typedef struct {
        int          x;
        int          y;
        logic [31:0] addr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        bl;
        logic        hs;
    } vec_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n_v = 2'b00;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       tbl [12];

    always #5 clk = ~clk;

    function automatic int clampi(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    // Expected outputs after t pixel ticks since reset release: rom_addr reflects
    // the last in-image pixel up to position t-1, the colour path shows pixel t-2.
    function automatic out_t model(input int t);
        out_t o;
        int q, x, y, n, a;
        logic img, vis;
        o = RESET_OUT;
        if (t >= 1) begin
            q = t - 1;
            x = q % HTOT;
            y = q / HTOT;
            n = clampi(y - TY0, 0, TH) * TW;
            if (y >= TY0 && y < TY0 + TH) n += clampi(x - TX0 + 1, 0, TW);
            o.addr = (n == 0) ? 32'd0 : 32'(n - 1);
        end
        if (t >= 2) begin
            q = t - 2;
            x = q % HTOT;
            y = q / HTOT;
            vis = (x < HVIS) && (y < VVIS);
            img = (x >= TX0) && (x < TX0 + TW) && (y >= TY0) && (y < TY0 + TH);
            a = (y - TY0) * TW + (x - TX0);
            if (img) begin
                o.r = 8'(a);
                o.g = ~8'(a);
                o.b = 8'(a + 37);
            end else if (vis) begin
                o.r = TBG;
                o.g = TBG;
                o.b = TBG;
            end
            o.hs = !((x >= HS_LO) && (x < HS_HI));
            o.vs = !((y >= VS_LO) && (y < VS_HI));
            o.bl = vis;
        end
        return o;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 2 : 4;
        logic [31:0] rom_addr;
        logic [23:0] red_d, green_d, blue_d;
        logic [7:0]  vga_r, vga_g, vga_b;
        logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
        int          cyc;
        int          fall1, fall2, n_fall, n_print;
        logic        prev_hs;
        out_t        got, want;

        vga_image_fetch #(
            .CLK_DIV(D), .IMG_W(TW), .IMG_H(TH), .X0(TX0), .Y0(TY0), .BG(TBG)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n_v[gi]),
            .rom_addr    (rom_addr),
            .red_data    (red_d),
            .green_data  (green_d),
            .blue_data   (blue_d),
            .vga_r       (vga_r),
            .vga_g       (vga_g),
            .vga_b       (vga_b),
            .vga_hsync   (vga_hsync),
            .vga_vsync   (vga_vsync),
            .vga_blank_n (vga_blank_n),
            .frame_start (frame_start)
        );

        // ROM models: one-clock registered read, random junk in the unused upper bits.
        always_ff @(posedge clk) begin
            red_d   <= {16'($urandom), rom_addr[7:0]};
            green_d <= {16'($urandom), ~rom_addr[7:0]};
            blue_d  <= {16'($urandom), rom_addr[7:0] + 8'd37};
        end

        initial begin
            cyc = 0;
            forever begin
                @(posedge clk or negedge rst_n_v[gi]);
                if (!rst_n_v[gi]) cyc = 0;
                else cyc = cyc + 1;
            end
        end

        initial begin
            n_fall  = 0;
            n_print = 0;
            fall1   = -1;
            fall2   = -1;
            prev_hs = 1'b1;
            forever begin
                @(negedge clk);
                want = model(cyc / D);
                got  = {rom_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank_n, frame_start};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    if (n_print < 8) begin
                        n_print++;
                        $display("FAIL stream div%0d tick=%0d: got addr=%0d rgb=%h/%h/%h hs=%b vs=%b bl=%b fs=%b, expected addr=%0d rgb=%h/%h/%h hs=%b vs=%b bl=%b fs=%b",
                                 D, cyc / D, got.addr, got.r, got.g, got.b, got.hs, got.vs, got.bl, got.fs,
                                 want.addr, want.r, want.g, want.b, want.hs, want.vs, want.bl, want.fs);
                    end
                end
                if (!rst_n_v[gi]) begin
                    n_fall = 0;
                    fall1  = -1;
                    fall2  = -1;
                end else if (prev_hs && !vga_hsync) begin
                    if (n_fall == 0) fall1 = cyc;
                    else if (n_fall == 1) fall2 = cyc;
                    n_fall++;
                end
                prev_hs = vga_hsync;
            end
        end
    end

    function automatic out_t get_out(input int sel);
        if (sel == 0)
            return {g_inst[0].rom_addr, g_inst[0].vga_r, g_inst[0].vga_g, g_inst[0].vga_b,
                    g_inst[0].vga_hsync, g_inst[0].vga_vsync, g_inst[0].vga_blank_n, g_inst[0].frame_start};
        return {g_inst[1].rom_addr, g_inst[1].vga_r, g_inst[1].vga_g, g_inst[1].vga_b,
                g_inst[1].vga_hsync, g_inst[1].vga_vsync, g_inst[1].vga_blank_n, g_inst[1].frame_start};
    endfunction

    function automatic int cur_ticks(input int sel);
        return (sel == 0) ? g_inst[0].cyc / 2 : g_inst[1].cyc / 4;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic wait_ticks(input int sel, input int target);
        int guard;
        guard = 0;
        while (cur_ticks(sel) < target && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= GUARD) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout inst%0d: reached tick %0d, expected tick %0d", sel, cur_ticks(sel), target);
        end
    endtask

    task automatic reset_pulse(input string nm, input int at_tick);
        int hold;
        wait_ticks(0, at_tick);
        #2 rst_n_v[0] = 1'b0;
        #1 check(nm, 64'(get_out(0)), 64'(RESET_OUT));
        hold = $urandom_range(1, 6);
        $display("reset %s at tick %0d (h=%0d v=%0d), held %0d clks", nm, at_tick,
                 at_tick % HTOT, at_tick / HTOT, hold);
        repeat (hold) @(negedge clk);
        #2 rst_n_v[0] = 1'b1;
    endtask

    task automatic run_reset_seq();
        reset_pulse("midframe_reset_img", TY0 * HTOT + HTOT + 300);
        reset_pulse("random_reset", $urandom_range(200, 3500));
        wait_ticks(0, 4200);
    endtask

    task automatic run_table();
        int p;
        out_t o;
        for (int i = 0; i < 12; i++) begin
            p = tbl[i].y * HTOT + tbl[i].x;
            wait_ticks(1, p + 1);
            o = get_out(1);
            check($sformatf("addr(%0d,%0d)", tbl[i].x, tbl[i].y), 64'(o.addr), 64'(tbl[i].addr));
            wait_ticks(1, p + 2);
            o = get_out(1);
            check($sformatf("pixel(%0d,%0d)", tbl[i].x, tbl[i].y),
                  64'({o.r, o.g, o.b, o.bl, o.hs}),
                  64'({tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].bl, tbl[i].hs}));
            $display("vec %0d (%0d,%0d): addr=%0d rgb=%h/%h/%h blank_n=%b hsync=%b", i, tbl[i].x, tbl[i].y,
                     tbl[i].addr, o.r, o.g, o.b, o.bl, o.hs);
        end
    endtask

    initial begin
        tbl[0]  = '{120, 1, 32'd0,    8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[1]  = '{119, 2, 32'd0,    8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[2]  = '{120, 2, 32'd0,    8'h00, 8'hFF, 8'h25, 1'b1, 1'b1};
        tbl[3]  = '{519, 2, 32'd399,  8'h8F, 8'h70, 8'hB4, 1'b1, 1'b1};
        tbl[4]  = '{520, 2, 32'd399,  8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[5]  = '{640, 2, 32'd399,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{120, 3, 32'd400,  8'h90, 8'h6F, 8'hB5, 1'b1, 1'b1};
        tbl[7]  = '{700, 3, 32'd799,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{519, 4, 32'd1199, 8'hAF, 8'h50, 8'hD4, 1'b1, 1'b1};
        tbl[9]  = '{639, 4, 32'd1199, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[10] = '{120, 5, 32'd1199, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[11] = '{300, 6, 32'd1199, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1};

        rst_n_v = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_state_div2", 64'(get_out(0)), 64'(RESET_OUT));
        check("reset_state_div4", 64'(get_out(1)), 64'(RESET_OUT));
        #2 rst_n_v = 2'b11;

        fork
            run_reset_seq();
            run_table();
        join

        check("first_hsync_fall_div2", 64'(g_inst[0].fall1), 64'(2 * (HS_LO + 2)));
        check("line_period_div2", 64'(g_inst[0].fall2 - g_inst[0].fall1), 64'(2 * HTOT));
        check("first_hsync_fall_div4", 64'(g_inst[1].fall1), 64'(4 * (HS_LO + 2)));
        check("line_period_div4", 64'(g_inst[1].fall2 - g_inst[1].fall1), 64'(4 * HTOT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
